// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter for a shared register bank.
// NREQ requesters compete for one write per cycle; a bank-wide sweep can
// clear or preset every register, one register per cycle. All outputs are
// registered, so a sampled request shows up on wr_en/ack one cycle later.
module reg_bank_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3,
  parameter int GW    = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  ack_err,
  output logic [GW-1:0]         grant_id,
  input  logic                  sweep_start,
  input  logic                  sweep_val,
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic [NREG-1:0]       wr_en,
  output logic [WIDTH-1:0]      wr_data
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [AW-1:0]   sweep_idx;
  logic            sweep_val_q;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [GW-1:0]   gnt;
  logic [AW-1:0]   gnt_addr;
  logic [WIDTH-1:0] gnt_data;
  logic            addr_ok;
  logic [AW-1:0]   sweep_next;

  // Pick the first eligible requester at or above ptr, wrapping mod NREQ.
  // The requester acked this cycle is masked so one transaction is never
  // written twice while its req is still high.
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise a path
    // that skips the assignment would infer a latch.
    elig  = req & ~ack;
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && elig[ptr + GW'(i)]) begin
        found = 1'b1;
        gnt   = ptr + GW'(i);
      end
    end
  end

  // Decode the selected requester's address and data.
  always_comb begin
    gnt_addr   = req_addr[int'(gnt)*AW +: AW];
    gnt_data   = req_data[int'(gnt)*WIDTH +: WIDTH];
    addr_ok    = int'(gnt_addr) < NREG;
    sweep_next = sweep_idx + AW'(1);
  end

  // Control FSM with registered outputs: arbitration in IDLE, one register
  // per cycle in SWEEP. Pulsed outputs default low each cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!arst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      sweep_idx   <= '0;
      sweep_val_q <= 1'b0;
      ack         <= '0;
      ack_err     <= 1'b0;
      grant_id    <= '0;
      sweep_busy  <= 1'b0;
      sweep_done  <= 1'b0;
      wr_en       <= '0;
      wr_data     <= '0;
    end else begin
      ack        <= '0;
      ack_err    <= 1'b0;
      wr_en      <= '0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_start) begin
            // Sweep wins over pending requests; index 0 is written next cycle.
            sweep_val_q <= sweep_val;
            sweep_idx   <= '0;
            state       <= SWEEP;
            sweep_busy  <= 1'b1;
            wr_en       <= NREG'(1);
            wr_data     <= {WIDTH{sweep_val}};
          end else if (found) begin
            ack      <= NREQ'(1) << gnt;
            grant_id <= gnt;
            wr_data  <= gnt_data;
            wr_en    <= addr_ok ? (NREG'(1) << gnt_addr) : '0;
            ack_err  <= !addr_ok;
            ptr      <= gnt + GW'(1);
          end
        end
        SWEEP: begin
          // sweep_start is ignored here; the running sweep is never restarted.
          if (sweep_idx == AW'(NREG - 1)) begin
            state      <= IDLE;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            sweep_idx <= sweep_next;
            wr_en     <= NREG'(1) << sweep_next;
            wr_data   <= {WIDTH{sweep_val_q}};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Self-checking bench for reg_bank_write_arbiter: a table of single-cycle
// vectors for arbitration, then hand-written sweep and reset sequences.
// AW is widened to 4 so that out-of-range addresses (>= NREG) are reachable.
module tb_reg_bank_write_arbiter;

  localparam int NREQ = 4, NREG = 8, WIDTH = 8, AW = 4, GW = 2;

  logic                  clk = 1'b0;
  logic                  arst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  ack_err;
  logic [GW-1:0]         grant_id;
  logic                  sweep_start;
  logic                  sweep_val;
  logic                  sweep_busy;
  logic                  sweep_done;
  logic [NREG-1:0]       wr_en;
  logic [WIDTH-1:0]      wr_data;

  int tests = 0;
  int fails = 0;

  reg_bank_write_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH), .AW(AW), .GW(GW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .ack(ack), .ack_err(ack_err), .grant_id(grant_id),
    .sweep_start(sweep_start), .sweep_val(sweep_val),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .wr_en(wr_en), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Addresses {r3,r2,r1,r0}; A_ERR puts 9 (>= NREG) on requester 2.
  localparam logic [15:0] A_OK  = 16'h3215;
  localparam logic [15:0] A_ERR = 16'h3915;
  localparam logic [31:0] D     = 32'h3322_11A5;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] addr;
    logic [3:0]  e_ack;
    logic [1:0]  e_gid;
    logic [7:0]  e_wen;
    logic [7:0]  e_wd;
    logic        e_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input logic [3:0] e_ack,
                     input logic [1:0] e_gid, input logic [7:0] e_wen,
                     input logic [7:0] e_wd, input logic e_err,
                     input logic e_busy, input logic e_done);
    check({tag, ".ack"}, 32'(ack), 32'(e_ack));
    if (e_ack != 4'b0) check({tag, ".grant_id"}, 32'(grant_id), 32'(e_gid));
    check({tag, ".wr_en"}, 32'(wr_en), 32'(e_wen));
    check({tag, ".wr_data"}, 32'(wr_data), 32'(e_wd));
    check({tag, ".ack_err"}, 32'(ack_err), 32'(e_err));
    check({tag, ".sweep_busy"}, 32'(sweep_busy), 32'(e_busy));
    check({tag, ".sweep_done"}, 32'(sweep_done), 32'(e_done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Arbitration vectors; each row's inputs are sampled on one edge and its
    // expected outputs are checked just after that edge.
    vecs[0]  = '{4'b0001, A_OK,  4'b0001, 2'd0, 8'h20, 8'hA5, 1'b0};
    vecs[1]  = '{4'b0000, A_OK,  4'b0000, 2'd0, 8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{4'b1111, A_OK,  4'b0010, 2'd1, 8'h02, 8'h11, 1'b0};
    vecs[3]  = '{4'b1111, A_OK,  4'b0100, 2'd2, 8'h04, 8'h22, 1'b0};
    vecs[4]  = '{4'b1111, A_OK,  4'b1000, 2'd3, 8'h08, 8'h33, 1'b0};
    vecs[5]  = '{4'b1111, A_OK,  4'b0001, 2'd0, 8'h20, 8'hA5, 1'b0};
    vecs[6]  = '{4'b1111, A_OK,  4'b0010, 2'd1, 8'h02, 8'h11, 1'b0};
    vecs[7]  = '{4'b0001, A_OK,  4'b0001, 2'd0, 8'h20, 8'hA5, 1'b0};
    vecs[8]  = '{4'b0001, A_OK,  4'b0000, 2'd0, 8'h00, 8'hA5, 1'b0};
    vecs[9]  = '{4'b0001, A_OK,  4'b0001, 2'd0, 8'h20, 8'hA5, 1'b0};
    vecs[10] = '{4'b0001, A_OK,  4'b0000, 2'd0, 8'h00, 8'hA5, 1'b0};
    vecs[11] = '{4'b0000, A_OK,  4'b0000, 2'd0, 8'h00, 8'hA5, 1'b0};
    vecs[12] = '{4'b0100, A_ERR, 4'b0100, 2'd2, 8'h00, 8'h22, 1'b1};
    // ptr must now be 3: requesters 0,1,3 pending, 3 wins.
    vecs[13] = '{4'b1011, A_OK,  4'b1000, 2'd3, 8'h08, 8'h33, 1'b0};
    vecs[14] = '{4'b0000, A_OK,  4'b0000, 2'd0, 8'h00, 8'h33, 1'b0};

    arst_n = 1'b0; req = '0; req_addr = A_OK; req_data = D;
    sweep_start = 1'b0; sweep_val = 1'b0;
    #12;
    cmp("reset", 4'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      req = vecs[i].req;
      req_addr = vecs[i].addr;
      step();
      cmp($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_gid, vecs[i].e_wen,
          vecs[i].e_wd, vecs[i].e_err, 1'b0, 1'b0);
    end

    // Preset sweep launched together with a pending request from requester 1;
    // a second sweep_start mid-sweep must change nothing.
    req = 4'b0010; req_addr = A_OK;
    sweep_start = 1'b1; sweep_val = 1'b1;
    for (int k = 0; k < NREG; k++) begin
      step();
      sweep_start = (k == 2);
      sweep_val = 1'b0;
      cmp($sformatf("sweep%0d", k), 4'b0, 2'd0, 8'(1 << k), 8'hFF, 1'b0,
          1'b1, 1'b0);
    end
    sweep_start = 1'b0;
    step();
    cmp("sweep_done", 4'b0, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    step();
    cmp("post_sweep_grant", 4'b0010, 2'd1, 8'h02, 8'h11, 1'b0, 1'b0, 1'b0);
    req = 4'b0000;
    step();
    cmp("post_sweep_idle", 4'b0, 2'd0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0);

    // Clear sweep aborted by reset at index 3.
    sweep_start = 1'b1; sweep_val = 1'b0;
    step();
    sweep_start = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    cmp("abort_pre", 4'b0, 2'd0, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0);
    arst_n = 1'b0;
    #1;
    cmp("abort_rst", 4'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    arst_n = 1'b1;
    step();
    cmp("abort_idle0", 4'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    cmp("abort_idle1", 4'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Pointer back at 0: all four held, grants rotate 0,1,2,3,0.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] g;
      logic [7:0] wen [4];
      logic [7:0] dat [4];
      wen = '{8'h20, 8'h02, 8'h04, 8'h08};
      dat = '{8'hA5, 8'h11, 8'h22, 8'h33};
      g = 2'(k % 4);
      step();
      cmp($sformatf("rr%0d", k), 4'(1 << g), g, wen[g], dat[g], 1'b0,
          1'b0, 1'b0);
    end
    req = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
